// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: opcodes, control steps, ALU codes, control word.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mini_src_pkg;

  // Opcode map, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // The ALU uses the opcode value itself as its operation code
  localparam logic [4:0] ALU_ADD = OP_ADD;
  localparam logic [4:0] ALU_AND = OP_AND;
  localparam logic [4:0] ALU_OR  = OP_OR;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } step_t;

  // One bit per datapath strobe plus the ALU operation code
  typedef struct packed {
    logic       pc_out;
    logic       zhigh_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       c_out;
    logic       inport_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       z_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       con_in;
    logic       outport_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic [4:0] alu_op;
  } ctrl_t;

  // Last execute step of each instruction; anything unrecognised is a one-step nop
  function automatic step_t final_step(input logic [4:0] op);
    step_t s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: s = S_T5;
      OP_LD, OP_ST:                     s = S_T7;
      OP_MUL, OP_DIV, OP_BR:            s = S_T6;
      OP_NEG, OP_NOT:                   s = S_T4;
      default:                          s = S_T3;
    endcase
    return s;
  endfunction

  // Immediate-form ALU instructions map onto their register-form operation
  function automatic logic [4:0] imm_alu_code(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mini_src_step_counter.sv
// Control step register: advances T0..T7, wraps to T0 or parks in HALT.
// Latency: one clock per step; async reset lands in T0 immediately.
// Backpressure: none; HALT is left only through reset.
module mini_src_step_counter
  import mini_src_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  last_step,
  input  logic  halt_req,
  output step_t step
);

  step_t step_nxt;

  // Next step: finish instruction to T0 (or HALT when requested), else advance
  always_comb begin
    step_nxt = step;
    if (step != S_HALT) begin
      if (last_step) begin
        step_nxt = halt_req ? S_HALT : S_T0;
      end else begin
        step_nxt = step_t'(step + 4'd1);
      end
    end
  end

  // Step register with asynchronous reset back to the fetch start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= S_T0;
    end else begin
      step <= step_nxt;
    end
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0-T2, execute T3-T7.
// Latency: strobes are decoded combinationally from the current step and opcode.
// Backpressure: none; stop/halt park the sequencer in HALT until reset.
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int IR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            run,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            Cout,
  output logic            InPortout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Zin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            CONin,
  output logic            OutPortin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic [OP_W-1:0] alu_op
);

  step_t      step;
  logic [4:0] op;
  logic       last_step;
  logic       halt_req;
  ctrl_t      ctrl;
  ctrl_t      ctrl_gated;
  logic       unused_ir;

  assign op = ir[IR_W-1 -: 5];
  // Register and constant fields are consumed by select/encode, not here
  assign unused_ir = ^ir[IR_W-6:0];

  assign last_step = (step == final_step(op));
  // halt opcode always parks; stop only matters on an instruction's last step
  assign halt_req  = stop | (op == OP_HALT);

  mini_src_step_counter u_step (
    .clk       (clk),
    .reset     (reset),
    .last_step (last_step),
    .halt_req  (halt_req),
    .step      (step)
  );

  // Decode the strobe set for the current (step, opcode) pair
  always_comb begin
    ctrl = '0;
    case (step)
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      S_HALT: begin
        ctrl = '0;
      end
      default: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            case (step)
              S_T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin
                ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = op; ctrl.z_in = 1'b1;
              end
              S_T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              S_T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin
                ctrl.c_out = 1'b1; ctrl.alu_op = imm_alu_code(op); ctrl.z_in = 1'b1;
              end
              S_T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          // ldi/ld/st share the effective-address computation Rb(or 0) + C
          OP_LDI, OP_LD, OP_ST: begin
            case (step)
              S_T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin ctrl.c_out = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.z_in = 1'b1; end
              S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (op == OP_LDI) begin
                  ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else begin
                  ctrl.mar_in = 1'b1;
                end
              end
              S_T6: begin
                if (op == OP_LD) begin
                  ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                  // MDR loads from the bus here, so read stays low
                  ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                end
              end
              S_T7: begin
                if (op == OP_LD) begin
                  ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (op == OP_ST) begin
                  ctrl.write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step)
              S_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T4: begin
                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = op; ctrl.z_in = 1'b1;
              end
              S_T5: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
              S_T6: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              S_T3: begin
                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.alu_op = op; ctrl.z_in = 1'b1;
              end
              S_T4: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              S_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              S_T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              S_T5: begin ctrl.c_out = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.z_in = 1'b1; end
              // Branch target is committed only when the condition holds
              S_T6: begin
                if (con_ff) begin
                  ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_JR: begin
            if (step == S_T3) begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
            end
          end
          OP_IN: begin
            if (step == S_T3) begin
              ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
          end
          OP_OUT: begin
            if (step == S_T3) begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1;
            end
          end
          OP_MFHI: begin
            if (step == S_T3) begin
              ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
          end
          OP_MFLO: begin
            if (step == S_T3) begin
              ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
          end
          // nop, jal (reserved), halt and undefined opcodes drive nothing
          default: ;
        endcase
      end
    endcase
  end

  // Reset kills every strobe at once so an aborted store cannot write
  assign ctrl_gated = reset ? '0 : ctrl;

  assign run       = (step != S_HALT);
  assign PCout     = ctrl_gated.pc_out;
  assign Zhighout  = ctrl_gated.zhigh_out;
  assign Zlowout   = ctrl_gated.zlow_out;
  assign MDRout    = ctrl_gated.mdr_out;
  assign HIout     = ctrl_gated.hi_out;
  assign LOout     = ctrl_gated.lo_out;
  assign Cout      = ctrl_gated.c_out;
  assign InPortout = ctrl_gated.inport_out;
  assign PCin      = ctrl_gated.pc_in;
  assign IRin      = ctrl_gated.ir_in;
  assign MARin     = ctrl_gated.mar_in;
  assign MDRin     = ctrl_gated.mdr_in;
  assign Zin       = ctrl_gated.z_in;
  assign Yin       = ctrl_gated.y_in;
  assign HIin      = ctrl_gated.hi_in;
  assign LOin      = ctrl_gated.lo_in;
  assign CONin     = ctrl_gated.con_in;
  assign OutPortin = ctrl_gated.outport_in;
  assign IncPC     = ctrl_gated.inc_pc;
  assign Read      = ctrl_gated.read;
  assign Write     = ctrl_gated.write;
  assign Gra       = ctrl_gated.gra;
  assign Grb       = ctrl_gated.grb;
  assign Grc       = ctrl_gated.grc;
  assign Rin       = ctrl_gated.r_in;
  assign Rout      = ctrl_gated.r_out;
  assign BAout     = ctrl_gated.ba_out;
  assign alu_op    = ctrl_gated.alu_op;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit: per-step strobe checks.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected strobe sets are written out by hand for each step.
module tb_mini_src_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        run;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, InPortout;
  logic        PCin, IRin, MARin, MDRin, Zin, Yin, HIin, LOin, CONin, OutPortin;
  logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_op;

  int checks = 0;
  int errors = 0;
  logic write_seen = 1'b0;

  localparam logic [26:0] M_PCOUT    = 27'd1 << 26;
  localparam logic [26:0] M_ZHIGHOUT = 27'd1 << 25;
  localparam logic [26:0] M_ZLOWOUT  = 27'd1 << 24;
  localparam logic [26:0] M_MDROUT   = 27'd1 << 23;
  localparam logic [26:0] M_CEOUT    = 27'd1 << 20;
  localparam logic [26:0] M_PCIN     = 27'd1 << 18;
  localparam logic [26:0] M_IRIN     = 27'd1 << 17;
  localparam logic [26:0] M_MARIN    = 27'd1 << 16;
  localparam logic [26:0] M_MDRIN    = 27'd1 << 15;
  localparam logic [26:0] M_ZIN      = 27'd1 << 14;
  localparam logic [26:0] M_YIN      = 27'd1 << 13;
  localparam logic [26:0] M_HIIN     = 27'd1 << 12;
  localparam logic [26:0] M_LOIN     = 27'd1 << 11;
  localparam logic [26:0] M_CONIN    = 27'd1 << 10;
  localparam logic [26:0] M_INCPC    = 27'd1 << 8;
  localparam logic [26:0] M_READ     = 27'd1 << 7;
  localparam logic [26:0] M_WRITE    = 27'd1 << 6;
  localparam logic [26:0] M_GRA      = 27'd1 << 5;
  localparam logic [26:0] M_GRB      = 27'd1 << 4;
  localparam logic [26:0] M_GRC      = 27'd1 << 3;
  localparam logic [26:0] M_RIN      = 27'd1 << 2;
  localparam logic [26:0] M_ROUT     = 27'd1 << 1;
  localparam logic [26:0] M_BAOUT    = 27'd1 << 0;

  localparam logic [26:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [26:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [26:0] F2 = M_MDROUT | M_IRIN;
  localparam logic [26:0] NONE = 27'd0;

  logic [26:0] strobes;
  assign strobes = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, InPortout,
                    PCin, IRin, MARin, MDRin, Zin, Yin, HIin, LOin, CONin, OutPortin,
                    IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

  mini_src_control_unit #(.OP_W(5), .IR_W(32)) dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (Write === 1'b1) write_seen <= 1'b1;

  task automatic tick();
    @(negedge clk);
  endtask

  // Compare {run, alu_op (when checked), strobes} against the expectation
  task automatic chk(input string tag, input logic [26:0] s, input logic a_chk,
                     input logic [4:0] a, input logic r);
    logic [32:0] obs;
    logic [32:0] exp;
    obs = {run, (a_chk ? alu_op : 5'd0), strobes};
    exp = {r, (a_chk ? a : 5'd0), s};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed run/alu/strobes=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch12(input string tag);
    tick(); chk({tag, "_t1"}, F1, 1'b0, 5'd0, 1'b1);
    tick(); chk({tag, "_t2"}, F2, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; con_ff = 1'b0; stop = 1'b0; ir = 32'h18918000;
    repeat (2) tick();
    chk("reset", NONE, 1'b1, 5'd0, 1'b1);
    reset = 1'b0; #1;
    chk("add_t0", F0, 1'b0, 5'd0, 1'b1);

    // add R1,R2,R3
    fetch12("add");
    tick(); chk("add_t3", M_GRB | M_ROUT | M_YIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("add_t4", M_GRC | M_ROUT | M_ZIN, 1'b1, 5'b00011, 1'b1);
    tick(); chk("add_t5", M_ZLOWOUT | M_GRA | M_RIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("add_next_t0", F0, 1'b0, 5'd0, 1'b1);

    // ld R1,0x55(R2)
    ir = 32'h00900055;
    fetch12("ld");
    tick(); chk("ld_t3", M_GRB | M_BAOUT | M_YIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("ld_t4", M_CEOUT | M_ZIN, 1'b1, 5'b00011, 1'b1);
    tick(); chk("ld_t5", M_ZLOWOUT | M_MARIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("ld_t6", M_READ | M_MDRIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("ld_t7", M_MDROUT | M_GRA | M_RIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("ld_next_t0", F0, 1'b0, 5'd0, 1'b1);

    // br, condition false then true
    ir = 32'h98800010;
    for (int pass = 0; pass < 2; pass++) begin
      con_ff = (pass == 1);
      fetch12("br");
      tick(); chk("br_t3", M_GRA | M_ROUT | M_CONIN, 1'b0, 5'd0, 1'b1);
      tick(); chk("br_t4", M_PCOUT | M_YIN, 1'b0, 5'd0, 1'b1);
      tick(); chk("br_t5", M_CEOUT | M_ZIN, 1'b1, 5'b00011, 1'b1);
      tick(); chk(pass == 1 ? "br_taken_t6" : "br_not_taken_t6",
                  pass == 1 ? (M_ZLOWOUT | M_PCIN) : NONE, 1'b0, 5'd0, 1'b1);
      tick(); chk("br_next_t0", F0, 1'b0, 5'd0, 1'b1);
    end
    con_ff = 1'b0;

    // mul with stop raised at T4: instruction still completes, then HALT
    ir = 32'h80880000;
    fetch12("mul");
    tick(); chk("mul_t3", M_GRA | M_ROUT | M_YIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("mul_t4", M_GRB | M_ROUT | M_ZIN, 1'b1, 5'b10000, 1'b1);
    stop = 1'b1;
    tick(); chk("mul_t5", M_ZLOWOUT | M_LOIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("mul_t6", M_ZHIGHOUT | M_HIIN, 1'b0, 5'd0, 1'b1);
    tick();
    stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("mul_halt", NONE, 1'b1, 5'd0, 1'b0);
      tick();
    end

    // reset leaves HALT; then st aborted by reset at T6
    reset = 1'b1; #1;
    chk("halt_reset", NONE, 1'b1, 5'd0, 1'b1);
    tick();
    ir = 32'h10900055;
    reset = 1'b0; #1;
    chk("st_t0", F0, 1'b0, 5'd0, 1'b1);
    fetch12("st");
    tick(); chk("st_t3", M_GRB | M_BAOUT | M_YIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("st_t4", M_CEOUT | M_ZIN, 1'b1, 5'b00011, 1'b1);
    tick(); chk("st_t5", M_ZLOWOUT | M_MARIN, 1'b0, 5'd0, 1'b1);
    tick(); chk("st_t6", M_GRA | M_ROUT | M_MDRIN, 1'b0, 5'd0, 1'b1);
    #1 reset = 1'b1;
    #1 chk("st_async_reset", NONE, 1'b1, 5'd0, 1'b1);
    tick(); tick();
    reset = 1'b0; #1;
    chk("st_after_reset_t0", F0, 1'b0, 5'd0, 1'b1);
    tick(); chk("st_after_reset_t1", F1, 1'b0, 5'd0, 1'b1);
    checks++;
    assert (write_seen === 1'b0) else begin
      errors++;
      $error("FAIL st_no_write observed write_seen=%b expected 0", write_seen);
    end

    // opcode 11111 behaves as nop; the fetch already in flight uses it
    ir = 32'hF8000000;
    tick(); chk("undef_t2", F2, 1'b0, 5'd0, 1'b1);
    tick(); chk("undef_t3", NONE, 1'b0, 5'd0, 1'b1);
    tick(); chk("undef_next_t0", F0, 1'b0, 5'd0, 1'b1);

    // halt opcode parks the sequencer until reset
    ir = 32'hD8000000;
    fetch12("halt");
    tick(); chk("halt_t3", NONE, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halt_state", NONE, 1'b1, 5'd0, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("halt_exit_t0", F0, 1'b0, 5'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
